// File: rtl/decode_issue_stage_if.sv
// Decode/issue stage bus: upstream instruction handshake, downstream
// decoded-instruction handshake, writeback notification and stall counter.
interface decode_issue_stage_if #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
);
    logic                 in_valid;
    logic [31:0]          in_instr;
    logic                 in_ready;
    logic                 out_valid;
    logic                 out_ready;
    logic [2:0]           out_op;
    logic [BITS_ADDR-1:0] out_rs1;
    logic [BITS_ADDR-1:0] out_rs2;
    logic [BITS_ADDR-1:0] out_rd;
    logic                 out_we;
    logic [BITS_DATA-1:0] out_imm;
    logic                 out_illegal;
    logic                 wb_valid;
    logic [BITS_ADDR-1:0] wb_addr;
    logic [15:0]          stall_cnt;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_addr,
        input  in_ready, out_valid, out_op, out_rs1, out_rs2,
        input  out_rd, out_we, out_imm, out_illegal, stall_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_addr,
        output in_ready, out_valid, out_op, out_rs1, out_rs2,
        output out_rd, out_we, out_imm, out_illegal, stall_cnt
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: decodes one instruction per cycle, tracks pending
// register writes in a scoreboard and stalls on RAW/WAW hazards.
module decode_issue_stage #(
    parameter int BITS_DATA = 32,
    parameter int BITS_ADDR = 3
) (
    input logic clk,
    input logic rst,
    decode_issue_stage_if.slave bus
);
    localparam int NREG = 1 << BITS_ADDR;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_ALUR  = 3'd1;
    localparam logic [2:0] OP_ALUI  = 3'd2;
    localparam logic [2:0] OP_LOAD  = 3'd3;
    localparam logic [2:0] OP_STORE = 3'd4;

    typedef struct packed {
        logic [2:0]           op;
        logic [BITS_ADDR-1:0] rs1;
        logic [BITS_ADDR-1:0] rs2;
        logic [BITS_ADDR-1:0] rd;
        logic                 we;
        logic [BITS_DATA-1:0] imm;
        logic                 illegal;
    } dec_t;

    logic [5:0] opcode;
    logic       isNop;
    logic       isAluR;
    logic       isAluI;
    logic       isLoad;
    logic       isStore;
    logic       unusedBit;

    dec_t dec;
    logic readA;
    logic readB;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] wbMask;
    logic [NREG-1:0] effPend;
    logic [NREG-1:0] pendNext;

    logic hazard;
    logic inReady;
    logic accept;

    dec_t        outQ;
    logic        outValid;
    logic [15:0] stallCnt;

    assign opcode    = bus.in_instr[31:26];
    assign unusedBit = bus.in_instr[16];

    assign isNop   = (opcode == 6'h00);
    assign isAluR  = (opcode == 6'h01);
    assign isAluI  = (opcode == 6'h02);
    assign isLoad  = (opcode == 6'h03);
    assign isStore = (opcode == 6'h04);

    // Register fields pass through raw; readA/readB/we say which matter.
    always_comb begin
        dec         = '0;
        readA       = 1'b0;
        readB       = 1'b0;
        dec.rd      = bus.in_instr[25:23];
        dec.rs1     = bus.in_instr[22:20];
        dec.rs2     = bus.in_instr[19:17];
        dec.imm     = BITS_DATA'($signed(bus.in_instr[15:0]));
        unique case (1'b1)
            isNop: begin
                dec.op = OP_NOP;
            end
            isAluR: begin
                dec.op = OP_ALUR;
                readA  = 1'b1;
                readB  = 1'b1;
                dec.we = 1'b1;
            end
            isAluI: begin
                dec.op = OP_ALUI;
                readA  = 1'b1;
                dec.we = 1'b1;
            end
            isLoad: begin
                dec.op = OP_LOAD;
                readA  = 1'b1;
                dec.we = 1'b1;
            end
            isStore: begin
                dec.op = OP_STORE;
                readA  = 1'b1;
                readB  = 1'b1;
            end
            default: begin
                dec.op      = OP_NOP;
                dec.illegal = 1'b1;
            end
        endcase
    end

    always_comb begin
        wbMask = '0;
        if (bus.wb_valid) begin
            wbMask[bus.wb_addr] = 1'b1;
        end
    end

    // A writeback landing this cycle already releases its register.
    assign effPend = pending & ~wbMask;

    assign hazard = bus.in_valid &
                    ((readA  & effPend[dec.rs1]) |
                     (readB  & effPend[dec.rs2]) |
                     (dec.we & effPend[dec.rd]));

    assign inReady = ~hazard & (~outValid | bus.out_ready);
    assign accept  = bus.in_valid & inReady;

    // Clear-then-set ordering makes a same-register issue win over writeback.
    always_comb begin
        pendNext = effPend;
        if (accept && dec.we) begin
            pendNext[dec.rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outQ     <= '0;
            outValid <= 1'b0;
            pending  <= '0;
            stallCnt <= '0;
        end else begin
            pending <= pendNext;
            if (accept) begin
                outQ     <= dec;
                outValid <= 1'b1;
            end else if (bus.out_ready) begin
                outValid <= 1'b0;
            end
            if (hazard && stallCnt != 16'hFFFF) begin
                stallCnt <= stallCnt + 16'd1;
            end
        end
    end

    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_op      = outQ.op;
    assign bus.out_rs1     = outQ.rs1;
    assign bus.out_rs2     = outQ.rs2;
    assign bus.out_rd      = outQ.rd;
    assign bus.out_we      = outQ.we;
    assign bus.out_imm     = outQ.imm;
    assign bus.out_illegal = outQ.illegal;
    assign bus.stall_cnt   = stallCnt;
endmodule
